// File: rtl/pool_wb_sched.sv
// Write-back scheduler: captures six pooled channel values per strobe into a
// two-bank ping-pong buffer and drains them as channel-major memory writes.
module pool_wb_sched #(
  parameter int N           = 7,
  parameter int im          = 28,
  parameter int pool_stride = 3,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2*N+1:0]    in1,
  input  logic [2*N+1:0]    in2,
  input  logic [2*N+1:0]    in3,
  input  logic [2*N+1:0]    in4,
  input  logic [2*N+1:0]    in5,
  input  logic [2*N+1:0]    in6,
  input  logic              in_valid,
  input  logic              pool_finish,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2*N+1:0]    wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int DW = 2*N + 2;
  localparam int P  = im / pool_stride;
  localparam int PP = P * P;
  localparam int CW = $clog2(PP + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        full_reg, full_next;
  logic              wbank_reg, rbank_reg;
  logic [2:0]        ch_reg;
  logic [CW-1:0]     pix_cnt_reg;
  logic [CW-1:0]     tag_reg [2];
  logic [DW-1:0]     val_reg [2][6];
  logic [DW-1:0]     in_arr  [6];
  logic [ADDR_W-1:0] addr_calc;
  logic              start_acc, drain, last_ch, can_cap, cap_req, capture, drop;
  logic              busy_next, done_next;

  assign in_arr[0] = in1;
  assign in_arr[1] = in2;
  assign in_arr[2] = in3;
  assign in_arr[3] = in4;
  assign in_arr[4] = in5;
  assign in_arr[5] = in6;

  assign addr_calc = ADDR_W'(ch_reg) * ADDR_W'(PP) + ADDR_W'(tag_reg[rbank_reg]);

  always_comb begin
    start_acc = (state_reg == IDLE) && start;
    drain     = full_reg[rbank_reg];
    last_ch   = drain && (ch_reg == 3'd5);
    // A full write bank may be reused in the very cycle its last word leaves.
    can_cap   = !full_reg[wbank_reg] || (last_ch && (wbank_reg == rbank_reg));
    cap_req   = (state_reg == RUN) && in_valid;
    capture   = cap_req && can_cap && (pix_cnt_reg != CW'(PP));
    drop      = cap_req && !capture;
    full_next = full_reg;
    if (last_ch) full_next[rbank_reg] = 1'b0;
    if (capture) full_next[wbank_reg] = 1'b1;
    if (start_acc) full_next = 2'b00;
  end

  // State register (busy/done registered alongside it)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (pool_finish) state_next = FLUSH;
      FLUSH:   if (full_reg == 2'b00) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_next = (state_next == RUN) || (state_next == FLUSH);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_reg    <= 2'b00;
      wbank_reg   <= 1'b0;
      rbank_reg   <= 1'b0;
      ch_reg      <= 3'd0;
      pix_cnt_reg <= '0;
      err         <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
    end else begin
      full_reg <= full_next;
      wr_en    <= drain;
      if (drain) begin
        wr_addr <= addr_calc;
        wr_data <= val_reg[rbank_reg][ch_reg];
      end
      if (start_acc) begin
        wbank_reg   <= 1'b0;
        rbank_reg   <= 1'b0;
        ch_reg      <= 3'd0;
        pix_cnt_reg <= '0;
        err         <= 1'b0;
      end else begin
        if (last_ch) begin
          ch_reg    <= 3'd0;
          rbank_reg <= ~rbank_reg;
        end else if (drain) begin
          ch_reg <= ch_reg + 3'd1;
        end
        if (capture) begin
          wbank_reg   <= ~wbank_reg;
          pix_cnt_reg <= pix_cnt_reg + 1'b1;
        end
        if (drop) err <= 1'b1;
      end
    end
  end

  // Bank payload needs no reset: the full flags gate every read of it.
  always_ff @(posedge clk) begin
    if (capture) begin
      tag_reg[wbank_reg] <= pix_cnt_reg;
      for (int c = 0; c < 6; c++) val_reg[wbank_reg][c] <= in_arr[c];
    end
  end

endmodule
